div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter_if.sv | 20 ++
 rtl/div_iter.sv | 134 +++++++++++++
 tb/tb_div_iter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
// Request/response bundle between the EX stage and the iterative divider.
interface div_iter_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_iter.sv
// Iterative 32/32 restoring divider, one quotient bit per clock.
// result_o = {remainder, quotient}; signed mode divides magnitudes and
// fixes the signs on the way out.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; outputs held at zero
// BY_ZERO | divisor was zero; one bubble before END with a zero result
// ON      | 32 restoring steps, counter tracks completed steps
// END     | result presented while start stays high
module div_iter (
  input  logic     clk,
  input  logic     rst,
  div_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BY_ZERO, ON, END} state_t;

  state_t      state, state_d;
  logic        ready_d;
  logic [63:0] result_d;

  logic [5:0]  cnt;
  logic [31:0] rem;        // partial remainder
  logic [31:0] dvd;        // dividend bits shifting out, quotient bits shifting in
  logic [31:0] dsr;        // divisor magnitude
  logic        neg_q;      // operand signs differed in signed mode
  logic        neg_r;      // dividend was negative in signed mode

  logic        take;
  logic        sgn1, sgn2;
  logic [31:0] mag1, mag2;
  logic [32:0] trial;
  logic [31:0] diff;
  logic        borrow;
  logic [31:0] q_fix, r_fix;

  // operand conditioning at latch time, one restoring step, and exit fixup
  always_comb begin
    take   = bus.start_i && !bus.annul_i && (bus.opdata2_i != 32'd0);
    sgn1   = bus.signed_div_i && bus.opdata1_i[31];
    sgn2   = bus.signed_div_i && bus.opdata2_i[31];
    mag1   = sgn1 ? (32'd0 - bus.opdata1_i) : bus.opdata1_i;
    mag2   = sgn2 ? (32'd0 - bus.opdata2_i) : bus.opdata2_i;
    trial  = {rem, dvd[31]};
    borrow = trial < {1'b0, dsr};
    // when there is no borrow the true difference is below dsr, so 32 bits hold it
    diff   = trial[31:0] - dsr;
    q_fix  = neg_q ? (32'd0 - dvd) : dvd;
    r_fix  = neg_r ? (32'd0 - rem) : rem;
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus.ready_o  <= 1'b0;
      bus.result_o <= 64'h0;
    end else begin
      state       <= state_d;
      bus.ready_o  <= ready_d;
      bus.result_o <= result_d;
    end
  end

  // next state and next output values
  always_comb begin
    state_d  = state;
    ready_d  = 1'b0;
    result_d = 64'h0;
    unique case (state)
      IDLE: begin
        if (bus.start_i && !bus.annul_i)
          state_d = (bus.opdata2_i == 32'd0) ? BY_ZERO : ON;
      end
      BY_ZERO: begin
        // END is entered with ready low; it rises on the following edge
        state_d = bus.annul_i ? IDLE : END;
      end
      ON: begin
        if (bus.annul_i) begin
          state_d = IDLE;
        end else if (cnt == 6'd32) begin
          state_d  = END;
          ready_d  = 1'b1;
          result_d = {r_fix, q_fix};
        end
      end
      END: begin
        if (bus.start_i) begin
          ready_d  = 1'b1;
          result_d = bus.result_o;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // operand latch and shift/subtract datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 6'd0;
      rem   <= 32'd0;
      dvd   <= 32'd0;
      dsr   <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            cnt   <= 6'd0;
            rem   <= 32'd0;
            dvd   <= mag1;
            dsr   <= mag2;
            neg_q <= sgn1 ^ sgn2;
            neg_r <= sgn1;
          end
        end
        ON: begin
          if (!bus.annul_i && cnt != 6'd32) begin
            rem <= borrow ? trial[31:0] : diff;
            dvd <= {dvd[30:0], ~borrow};
            cnt <= cnt + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
module tb_div_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_iter_if bus ();

  div_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain integer division; SV truncates toward zero and the
  // remainder follows the dividend, which is exactly the required behaviour.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint x, y, q, r;
    if (b == 32'd0) return 64'h0;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic watch_quiet(input string name, input int n);
    logic bad;
    bad = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) bad = 1'b1;
    end
    chk(name, {63'd0, bad}, 64'd0);
  endtask

  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] exp, input int exp_lat,
                       input int hold, input logic annul_end);
    int lat;
    logic got, busy_bad, stable_bad;
    logic [63:0] snap;
    @(posedge clk); #1;
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    @(posedge clk); #1;                    // start sampled on this edge
    busy_bad = (bus.ready_o !== 1'b0) || (bus.result_o !== 64'h0);
    bus.opdata1_i    = $urandom;           // must not reach the result
    bus.opdata2_i    = $urandom;
    bus.signed_div_i = ~s;
    lat = 0;
    got = 1'b0;
    while (lat < 100 && !got) begin
      @(posedge clk); #1;
      lat++;
      if (bus.ready_o === 1'b1) got = 1'b1;
      else if (bus.result_o !== 64'h0) busy_bad = 1'b1;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_result"}, bus.result_o, exp);
    chk({name, "_zero_while_busy"}, {63'd0, busy_bad}, 64'd0);
    snap = bus.result_o;
    stable_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      bus.annul_i = annul_end;
      @(posedge clk); #1;
      if (bus.ready_o !== 1'b1 || bus.result_o !== snap) stable_bad = 1'b1;
    end
    if (hold > 0) chk({name, "_hold_stable"}, {63'd0, stable_bad}, 64'd0);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    @(posedge clk); #1;
    chk({name, "_drop_ready"}, {63'd0, bus.ready_o}, 64'd0);
    chk({name, "_drop_result"}, bus.result_o, 64'h0);
  endtask

  task automatic start_only(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(posedge clk); #1;
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    vecs[0] = '{"u100_7",      32'd100,        32'd7,          1'b0, 64'h00000002_0000000E, 33, 5};
    vecs[1] = '{"s_m7_2",      32'hFFFFFFF9,   32'h00000002,   1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 1};
    vecs[2] = '{"s_7_m2",      32'h00000007,   32'hFFFFFFFE,   1'b1, 64'h00000001_FFFFFFFD, 33, 0};
    vecs[3] = '{"u_div0",      32'd5,          32'd0,          1'b0, 64'h0,                 2,  2};
    vecs[4] = '{"s_div0",      32'd5,          32'd0,          1'b1, 64'h0,                 2,  0};
    vecs[5] = '{"s_ovf",       32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h00000000_80000000, 33, 0};
    vecs[6] = '{"u_80_ff",     32'h80000000,   32'hFFFFFFFF,   1'b0, 64'h80000000_00000000, 33, 0};
    vecs[7] = '{"u_ff_1",      32'hFFFFFFFF,   32'd1,          1'b0, 64'h00000000_FFFFFFFF, 33, 1};
    vecs[8] = '{"s_m100_m7",   32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 64'hFFFFFFFE_0000000E, 33, 0};

    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {63'd0, bus.ready_o}, 64'd0);
    chk("reset_result", bus.result_o, 64'h0);
    rst = 1'b0;

    foreach (vecs[i])
      do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp,
            vecs[i].lat, vecs[i].hold, 1'b0);

    // annul in END is ignored
    do_op("annul_in_end", 32'd1000, 32'd33, 1'b0, model(32'd1000, 32'd33, 1'b0), 33, 3, 1'b1);

    // annul at step 10, then a fresh divide
    start_only(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    watch_quiet("annul_step10_quiet", 40);
    bus.annul_i = 1'b0;
    do_op("after_annul", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 0, 1'b0);

    // annul while in BY_ZERO
    start_only(32'd5, 32'd0, 1'b0);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    watch_quiet("annul_by_zero_quiet", 8);
    bus.annul_i = 1'b0;

    // annul in IDLE suppresses start
    @(posedge clk); #1;
    bus.opdata1_i = 32'd9;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    watch_quiet("annul_idle_quiet", 40);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;

    // reset at step 20
    start_only(32'd100, 32'd7, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_ready", {63'd0, bus.ready_o}, 64'd0);
    chk("rst_mid_result", bus.result_o, 64'h0);
    rst = 1'b0;
    watch_quiet("rst_mid_quiet", 40);

    // reset while presenting a result in END, start still high
    start_only(32'd77, 32'd5, 1'b0);
    repeat (36) @(posedge clk);
    #1;
    chk("end_before_rst_ready", {63'd0, bus.ready_o}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_end_ready", {63'd0, bus.ready_o}, 64'd0);
    chk("rst_end_result", bus.result_o, 64'h0);
    bus.start_i = 1'b0;
    rst = 1'b0;
    watch_quiet("rst_end_quiet", 3);

    // randomized operands against the reference model
    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 300));
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      s = 1'($urandom_range(0, 1));
      do_op($sformatf("rand%0d", n), a, b, s, model(a, b, s),
            (b == 32'd0) ? 2 : 33, $urandom_range(0, 3), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
